// File: rtl/irq_pulse_gen_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : irq_pkg (package)
// Description : Shared types and constants for the irq_pulse_gen block:
//               pulse FSM state encoding, register map addresses and the
//               default pulse/gap lengths.
// Revision    : 1.0 - initial release
// ============================================================================
package irq_pkg;

    // Pulse FSM state; the encoding is software-visible through STAT[1:0].
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAP  = 2'd2
    } irq_state_e;

    // Register map
    localparam logic [1:0] IRQ_ADDR_PENDING   = 2'd0;
    localparam logic [1:0] IRQ_ADDR_MASK      = 2'd1;
    localparam logic [1:0] IRQ_ADDR_ANNOUNCED = 2'd2;
    localparam logic [1:0] IRQ_ADDR_STAT      = 2'd3;

    // Default announcement shape
    localparam int IRQ_DEF_PULSE_CYC = 8;
    localparam int IRQ_DEF_GAP_CYC   = 4;

    function automatic int irq_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage : irq_pkg
`default_nettype wire

// File: rtl/irq_pulse_gen_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : irq_pulse_gen_if
// Description : Software register port of irq_pulse_gen.
//               wr_en/wr_addr/wr_data : single-cycle register write
//               rd_addr/rd_data       : combinational register read
//               master = software side, slave = irq_pulse_gen.
// Revision    : 1.0 - initial release
// ============================================================================
interface irq_pulse_gen_if #(
    parameter int N_SRC = 4
);
    logic             wr_en;
    logic [1:0]       wr_addr;
    logic [N_SRC-1:0] wr_data;
    logic [1:0]       rd_addr;
    logic [N_SRC-1:0] rd_data;

    modport master (
        output wr_en,
        output wr_addr,
        output wr_data,
        output rd_addr,
        input  rd_data
    );

    modport slave (
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        input  rd_addr,
        output rd_data
    );
endinterface : irq_pulse_gen_if
`default_nettype wire

// File: rtl/irq_pulse_gen_timer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : irq_pulse_timer
// Description : Announcement shaper. A fire request seen in IDLE produces a
//               PULSE_CYC-cycle high phase followed by a GAP_CYC-cycle low
//               phase before the next request can be accepted.
// Ports       : clock     - rising-edge clock
//               reset     - synchronous active-high reset
//               fire      - request an announcement (only honoured in IDLE)
//               busy_high - registered, high exactly while in HIGH
//               state     - current FSM state
// Revision    : 1.0 - initial release
// ============================================================================
module irq_pulse_timer
    import irq_pkg::*;
#(
    parameter int PULSE_CYC = IRQ_DEF_PULSE_CYC,
    parameter int GAP_CYC   = IRQ_DEF_GAP_CYC
) (
    input  wire logic clock,
    input  wire logic reset,
    input  wire logic fire,
    output logic      busy_high,
    output irq_state_e state
);

    // The counter only ever holds a phase length minus one.
    localparam int CNT_W = $clog2(irq_max(PULSE_CYC, GAP_CYC));

    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYC - 1);

    irq_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_high_q;

    // busy_high_q is assigned alongside each state transition so that it
    // always equals (next state == HIGH) without a decode after the flop.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            busy_high_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (fire) begin
                        state_q     <= HIGH;
                        cnt_q       <= PULSE_LOAD;
                        busy_high_q <= 1'b1;
                    end else begin
                        busy_high_q <= 1'b0;
                    end
                end
                HIGH: begin
                    if (cnt_q == '0) begin
                        state_q     <= GAP;
                        cnt_q       <= GAP_LOAD;
                        busy_high_q <= 1'b0;
                    end else begin
                        cnt_q       <= cnt_q - 1'b1;
                        busy_high_q <= 1'b1;
                    end
                end
                GAP: begin
                    busy_high_q <= 1'b0;
                    if (cnt_q == '0) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    cnt_q       <= '0;
                    busy_high_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy_high = busy_high_q;
    assign state     = state_q;

endmodule : irq_pulse_timer
`default_nettype wire

// File: rtl/irq_pulse_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : irq_pulse_gen
// Description : Source-side interrupt generator. Event pulses set PENDING
//               bits; masked, not-yet-announced pending bits trigger a
//               stretched pulse on irq_out with an enforced low gap.
// Ports       : clock     - rising-edge clock
//               reset     - synchronous active-high reset
//               ev        - per-source event pulses
//               bus       - register port (irq_pulse_gen_if.slave)
//                           addr 0 PENDING (W1C), 1 MASK (R/W),
//                           2 ANNOUNCED (RO), 3 STAT (RO, [1:0]=FSM state)
//               irq_out   - registered interrupt pulse
//               irq_level - registered |(PENDING & MASK), only present
//                           when IRQ_PULSE_GEN_LEVEL_EN is defined
// Config      : IRQ_PULSE_GEN_LEVEL_EN adds the irq_level output.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_pulse_gen
    import irq_pkg::*;
#(
    parameter int N_SRC     = 4,                  // 1..16
    parameter int PULSE_CYC = IRQ_DEF_PULSE_CYC,  // >= 2
    parameter int GAP_CYC   = IRQ_DEF_GAP_CYC     // >= 1
) (
    input  wire logic             clock,
    input  wire logic             reset,
    input  wire logic [N_SRC-1:0] ev,
    irq_pulse_gen_if.slave        bus,
    output logic                  irq_out
`ifdef IRQ_PULSE_GEN_LEVEL_EN
    ,
    output logic                  irq_level
`endif
);

    logic [N_SRC-1:0] pend_q, pend_d;
    logic [N_SRC-1:0] mask_q, mask_d;
    logic [N_SRC-1:0] ann_q,  ann_d;

    logic [N_SRC-1:0] fresh;
    logic [N_SRC-1:0] w1c;
    logic [N_SRC-1:0] ann_set;
    logic             fire;
    logic             announce;
    logic             busy_high;
    irq_state_e       state;
    logic [1:0]       state_bits;
    logic [N_SRC-1:0] rd_data_c;

    // ------------------------------------------------------------------
    // Trigger
    // ------------------------------------------------------------------
    assign fresh    = pend_q & mask_q & ~ann_q;
    assign fire     = |fresh;
    // The timer only honours fire in IDLE, so ANNOUNCED must be updated
    // under the same condition or bits would be marked without a pulse.
    assign announce = fire && (state == IDLE);
    assign ann_set  = announce ? (pend_q & mask_q) : '0;

    // ------------------------------------------------------------------
    // Register next-state
    // ------------------------------------------------------------------
    always_comb begin
        w1c    = '0;
        mask_d = mask_q;
        if (bus.wr_en) begin
            if (bus.wr_addr == IRQ_ADDR_PENDING) begin
                w1c = bus.wr_data;
            end
            if (bus.wr_addr == IRQ_ADDR_MASK) begin
                mask_d = bus.wr_data;
            end
        end
        // Event set takes priority over a same-cycle W1C.
        pend_d = (pend_q & ~w1c) | ev;
        // Qualifying with pend_d drops the announced mark in the same edge
        // that clears the pending bit, so a re-fire is seen as fresh.
        ann_d  = (ann_q | ann_set) & pend_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pend_q <= '0;
            mask_q <= '1;
            ann_q  <= '0;
        end else begin
            pend_q <= pend_d;
            mask_q <= mask_d;
            ann_q  <= ann_d;
        end
    end

    // ------------------------------------------------------------------
    // Pulse shaper
    // ------------------------------------------------------------------
    irq_pulse_timer #(
        .PULSE_CYC (PULSE_CYC),
        .GAP_CYC   (GAP_CYC)
    ) u_timer (
        .clock     (clock),
        .reset     (reset),
        .fire      (fire),
        .busy_high (busy_high),
        .state     (state)
    );

    assign irq_out = busy_high;

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    assign state_bits = state;

    always_comb begin
        rd_data_c = '0;
        case (bus.rd_addr)
            IRQ_ADDR_PENDING:   rd_data_c = pend_q;
            IRQ_ADDR_MASK:      rd_data_c = mask_q;
            IRQ_ADDR_ANNOUNCED: rd_data_c = ann_q;
            IRQ_ADDR_STAT:      rd_data_c = N_SRC'(state_bits);
            default:            rd_data_c = '0;
        endcase
    end

    assign bus.rd_data = rd_data_c;

    // ------------------------------------------------------------------
    // Optional level interrupt
    // ------------------------------------------------------------------
`ifdef IRQ_PULSE_GEN_LEVEL_EN
    logic level_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            level_q <= 1'b0;
        end else begin
            level_q <= |(pend_q & mask_q);
        end
    end

    assign irq_level = level_q;
`else
`endif

endmodule : irq_pulse_gen
`default_nettype wire
